// File: rtl/logic_proc_core.sv
// ---------------------------------------------------------------------------
// logic_proc_core
//   Parametrised bit-serial logic processor. Two WIDTH-bit shift registers
//   (A, B) are stepped one bit per clock through a per-bit function unit (F)
//   and a routing stage (R). One operation takes exactly WIDTH shift cycles.
//
// Ports
//   Clk      in   1      system clock, rising-edge active
//   Reset_n  in   1      asynchronous active-low reset
//   LoadA    in   1      IDLE only: A <= Din
//   LoadB    in   1      IDLE only: B <= Din
//   Execute  in   1      IDLE only, no load active: start one operation
//   Din      in   WIDTH  parallel load data
//   F        in   3      bit function select, captured at start
//   R        in   2      routing select, captured at start
//   A        out  WIDTH  register A contents
//   B        out  WIDTH  register B contents
//   Busy     out  1      high while shifting
//   Done     out  1      high from completion until Execute is released
// ---------------------------------------------------------------------------
module logic_proc_core #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          SHIFT_LEFT = 1'b0
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             LoadA,
    input  logic             LoadB,
    input  logic             Execute,
    input  logic [WIDTH-1:0] Din,
    input  logic [2:0]       F,
    input  logic [1:0]       R,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [2:0]       f_q,     f_d;
    logic [1:0]       r_q,     r_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    // Bit-step datapath signals
    logic             bit_a, bit_b, bit_f;
    logic             new_a, new_b;
    logic [WIDTH-1:0] a_shift, b_shift;

    // Bits leaving the registers this step
    always_comb begin
        if (SHIFT_LEFT) begin
            bit_a = a_q[WIDTH-1];
            bit_b = b_q[WIDTH-1];
        end else begin
            bit_a = a_q[0];
            bit_b = b_q[0];
        end
    end

    // Function unit, driven by the F value latched at start
    always_comb begin
        bit_f = 1'b0;
        unique case (f_q)
            3'b000:  bit_f = bit_a & bit_b;
            3'b001:  bit_f = bit_a | bit_b;
            3'b010:  bit_f = bit_a ^ bit_b;
            3'b011:  bit_f = 1'b1;
            3'b100:  bit_f = ~(bit_a & bit_b);
            3'b101:  bit_f = ~(bit_a | bit_b);
            3'b110:  bit_f = ~(bit_a ^ bit_b);
            default: bit_f = 1'b0;
        endcase
    end

    // Routing stage, driven by the R value latched at start
    always_comb begin
        new_a = bit_a;
        new_b = bit_b;
        unique case (r_q)
            2'b00: begin new_a = bit_a; new_b = bit_b; end
            2'b01: begin new_a = bit_a; new_b = bit_f; end
            2'b10: begin new_a = bit_f; new_b = bit_b; end
            default: begin new_a = bit_b; new_b = bit_a; end
        endcase
    end

    // Routed bits re-enter at the opposite end, so after WIDTH steps every
    // bit is back in its original position and the op acts on whole words.
    always_comb begin
        if (SHIFT_LEFT) begin
            a_shift = {a_q[WIDTH-2:0], new_a};
            b_shift = {b_q[WIDTH-2:0], new_b};
        end else begin
            a_shift = {new_a, a_q[WIDTH-1:1]};
            b_shift = {new_b, b_q[WIDTH-1:1]};
        end
    end

    // Control FSM and register update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f_d     = f_q;
        r_d     = r_q;
        a_d     = a_q;
        b_d     = b_q;

        unique case (state_q)
            ST_IDLE: begin
                if (LoadA) a_d = Din;
                if (LoadB) b_d = Din;
                // A load on this edge blocks start; Execute is re-sampled next edge
                if (Execute && !LoadA && !LoadB) begin
                    f_d     = F;
                    r_d     = R;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_d   = a_shift;
                b_d   = b_shift;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!Execute) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status flags are registered from the next state so they line up with it
    always_comb begin
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            f_q     <= '0;
            r_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f_q     <= f_d;
            r_q     <= r_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign A    = a_q;
    assign B    = b_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: tb/tb_logic_proc_core.sv
module tb_logic_proc_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 8-bit, right-shift instance
    logic       la8, lb8, ex8;
    logic [7:0] din8;
    logic [2:0] f8;
    logic [1:0] r8;
    logic [7:0] a8, b8;
    logic       busy8, done8;

    // 16-bit, left-shift instance
    logic        la16, lb16, ex16;
    logic [15:0] din16;
    logic [2:0]  f16;
    logic [1:0]  r16;
    logic [15:0] a16, b16;
    logic        busy16, done16;

    logic_proc_core #(.WIDTH(8), .SHIFT_LEFT(1'b0)) dut8 (
        .Clk(clk), .Reset_n(rst_n), .LoadA(la8), .LoadB(lb8), .Execute(ex8),
        .Din(din8), .F(f8), .R(r8), .A(a8), .B(b8), .Busy(busy8), .Done(done8)
    );

    logic_proc_core #(.WIDTH(16), .SHIFT_LEFT(1'b1)) dut16 (
        .Clk(clk), .Reset_n(rst_n), .LoadA(la16), .LoadB(lb16), .Execute(ex16),
        .Din(din16), .F(f16), .R(r16), .A(a16), .B(b16), .Busy(busy16), .Done(done16)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    // Monitors: count Busy cycles, and on each rising Done pop and compare
    int   bc8 = 0, bc16 = 0;
    logic dp8 = 1'b0, dp16 = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            bc8 = 0;
            dp8 = 1'b0;
        end else begin
            if (busy8) bc8++;
            if (done8 && !dp8) begin
                if (q8.size() == 0) begin
                    total_cnt++;
                    $display("FAIL done8_unexpected: actual=1 required=0");
                end else begin
                    exp_t e;
                    e = q8.pop_front();
                    chk("op8_A", {8'h00, a8}, e.a);
                    chk("op8_B", {8'h00, b8}, e.b);
                    chk("op8_busy_cycles", 16'(bc8), 16'(e.cyc));
                end
                bc8 = 0;
            end
            dp8 = done8;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            bc16 = 0;
            dp16 = 1'b0;
        end else begin
            if (busy16) bc16++;
            if (done16 && !dp16) begin
                if (q16.size() == 0) begin
                    total_cnt++;
                    $display("FAIL done16_unexpected: actual=1 required=0");
                end else begin
                    exp_t e;
                    e = q16.pop_front();
                    chk("op16_A", a16, e.a);
                    chk("op16_B", b16, e.b);
                    chk("op16_busy_cycles", 16'(bc16), 16'(e.cyc));
                end
                bc16 = 0;
            end
            dp16 = done16;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load8(input logic [7:0] a, input logic [7:0] b);
        la8 = 1'b1; din8 = a; step();
        la8 = 1'b0; lb8 = 1'b1; din8 = b; step();
        lb8 = 1'b0;
    endtask

    task automatic wait_done8(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done8) begin ok = 1'b1; break; end
            step();
        end
        if (!ok) begin
            total_cnt++;
            $display("FAIL %s: Done actual=0 required=1 (timeout)", name);
        end
    endtask

    // Full operation on dut8; disturb=1 changes F/R and raises LoadA mid-shift
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f,
                       input logic [1:0] r, input logic [7:0] ea, input logic [7:0] eb,
                       input bit disturb, input string name);
        load8(a, b);
        f8 = f; r8 = r; ex8 = 1'b1;
        q8.push_back('{{8'h00, ea}, {8'h00, eb}, 8});
        step();
        if (disturb) begin
            step(); step();
            f8 = 3'b111; r8 = 2'b10; la8 = 1'b1; din8 = 8'hFF;
        end
        wait_done8(name);
        la8 = 1'b0;
        step(); step(); step();
        chk({name, "_done_held"}, {15'd0, done8}, 16'd1);
        chk({name, "_busy_in_hold"}, {15'd0, busy8}, 16'd0);
        ex8 = 1'b0;
        step();
        chk({name, "_done_drop"}, {15'd0, done8}, 16'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        la8 = 0; lb8 = 0; ex8 = 0; din8 = '0; f8 = '0; r8 = '0;
        la16 = 0; lb16 = 0; ex16 = 0; din16 = '0; f16 = '0; r16 = '0;
        #2;
        chk("rst_A", {8'h00, a8}, 16'h0000);
        chk("rst_B", {8'h00, b8}, 16'h0000);
        chk("rst_busy", {15'd0, busy8}, 16'd0);
        chk("rst_done", {15'd0, done8}, 16'd0);
        #10;
        rst_n = 1'b1;
        step();

        // AND routed into B: B = 33 & 55 = 11, A unchanged
        op8(8'h33, 8'h55, 3'b000, 2'b01, 8'h33, 8'h11, 1'b0, "and_r01");
        // XOR routed into A: A = F0 ^ 3C = CC
        op8(8'hF0, 8'h3C, 3'b010, 2'b10, 8'hCC, 8'h3C, 1'b0, "xor_r10");
        // Swap
        op8(8'hF0, 8'h3C, 3'b010, 2'b11, 8'h3C, 8'hF0, 1'b0, "swap_r11");
        // F/R change and LoadA mid-shift have no effect
        op8(8'h33, 8'h55, 3'b000, 2'b01, 8'h33, 8'h11, 1'b1, "midshift_ignore");
        // Constant-one function into B
        op8(8'h12, 8'h34, 3'b011, 2'b01, 8'h12, 8'hFF, 1'b0, "one_r01");

        // Load and Execute on the same edge: load wins, start next edge
        lb8 = 1'b1; din8 = 8'h0F; step();
        lb8 = 1'b0;
        la8 = 1'b1; din8 = 8'hA5; f8 = 3'b010; r8 = 2'b01; ex8 = 1'b1;
        q8.push_back('{16'h00A5, 16'h00AA, 8});
        step();
        chk("load_wins_busy", {15'd0, busy8}, 16'd0);
        chk("load_wins_A", {8'h00, a8}, 16'h00A5);
        la8 = 1'b0;
        step();
        chk("start_next_edge_busy", {15'd0, busy8}, 16'd1);
        wait_done8("load_then_exec");
        begin
            int seen = 0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (busy8 || !done8) seen++;
            end
            chk("no_retrigger", 16'(seen), 16'd0);
        end
        ex8 = 1'b0;
        step();

        // Reset mid-shift aborts immediately
        load8(8'h33, 8'h55);
        f8 = 3'b000; r8 = 2'b01; ex8 = 1'b1;
        step(); step(); step();
        chk("pre_abort_busy", {15'd0, busy8}, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_A", {8'h00, a8}, 16'h0000);
        chk("abort_B", {8'h00, b8}, 16'h0000);
        chk("abort_busy", {15'd0, busy8}, 16'd0);
        chk("abort_done", {15'd0, done8}, 16'd0);
        ex8 = 1'b0;
        @(negedge clk); #2;
        rst_n = 1'b1;
        step();
        chk("post_abort_idle", {15'd0, busy8 | done8}, 16'd0);

        // 16-bit left-shift: NAND(00FF, 0F0F) into B = FFF0
        la16 = 1'b1; din16 = 16'h00FF; step();
        la16 = 1'b0; lb16 = 1'b1; din16 = 16'h0F0F; step();
        lb16 = 1'b0;
        f16 = 3'b100; r16 = 2'b01; ex16 = 1'b1;
        q16.push_back('{16'h00FF, 16'hFFF0, 16});
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 60; i++) begin
                step();
                if (done16) begin ok = 1'b1; break; end
            end
            if (!ok) begin
                total_cnt++;
                $display("FAIL nand16: Done actual=0 required=1 (timeout)");
            end
        end
        ex16 = 1'b0;
        step();
        chk("nand16_done_drop", {15'd0, done16}, 16'd0);
        // Left-shift XOR into A: 1234 ^ FFFF = EDCB
        la16 = 1'b1; din16 = 16'h1234; step();
        la16 = 1'b0; lb16 = 1'b1; din16 = 16'hFFFF; step();
        lb16 = 1'b0;
        f16 = 3'b010; r16 = 2'b10; ex16 = 1'b1;
        q16.push_back('{16'hEDCB, 16'hFFFF, 16});
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 60; i++) begin
                step();
                if (done16) begin ok = 1'b1; break; end
            end
            if (!ok) begin
                total_cnt++;
                $display("FAIL xor16: Done actual=0 required=1 (timeout)");
            end
        end
        ex16 = 1'b0;
        step(); step();

        chk("q8_drained", 16'(q8.size()), 16'd0);
        chk("q16_drained", 16'(q16.size()), 16'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
